// File: rtl/result_collector.sv
// result_collector: circular result buffer, first-word fall-through head.
// Ports: clk, rst (async active-low), wrReq/wrData push, clr flush,
// outData/outValid/outReady pop, full, empty, count, ovf (sticky drop).
// Optional: define RESULT_COLLECTOR_OVF_EN to enable the ovf register.
module result_collector #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wrReq,
  input  logic [WIDTH-1:0]           wrData,
  input  logic                       clr,
  output logic [WIDTH-1:0]           outData,
  output logic                       outValid,
  input  logic                       outReady,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             pop;
  logic             push;
  logic             drop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign outValid = ~empty;
  assign count    = cnt;
  assign outData  = mem[rptr];

  // A full buffer still accepts a write when the head leaves
  // in the same cycle; otherwise the word is dropped.
  assign pop  = outValid & outReady;
  assign push = wrReq & (~full | pop);
  assign drop = wrReq & full & ~pop;

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wptr] <= wrData;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef RESULT_COLLECTOR_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: randomized and directed checks of result_collector
// against a queue-based reference model.
module tb_result_collector;

  localparam int W = 16;
  localparam int D = 4;
`ifdef RESULT_COLLECTOR_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wrReq = 1'b0;
  logic [W-1:0] wrData = '0;
  logic         clr = 1'b0;
  logic         outReady = 1'b0;
  logic [W-1:0] outData;
  logic         outValid;
  logic         full;
  logic         empty;
  logic [2:0]   count;
  logic         ovf;

  result_collector #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .wrReq(wrReq), .wrData(wrData),
    .clr(clr), .outData(outData), .outValid(outValid),
    .outReady(outReady), .full(full), .empty(empty),
    .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];
  bit ovf_m = 1'b0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmp_model(string tag);
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".valid"}, 32'(outValid), 32'(q.size() != 0));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(q.size() == D));
    check({tag, ".ovf"}, 32'(ovf), 32'(ovf_m));
    if (q.size() != 0)
      check({tag, ".data"}, 32'(outData), 32'(q[0]));
  endtask

  // Called just after a falling edge; returns at the next one.
  task automatic step(bit wr, logic [W-1:0] d, bit rdy, bit c);
    bit pv, ps, dr, fl;
    wrReq = wr;
    wrData = d;
    outReady = rdy;
    clr = c;
    fl = (q.size() == D);
    pv = (q.size() != 0) && rdy;
    ps = wr && (!fl || pv);
    dr = wr && fl && !pv;
    if (dr && OVF_EN) ovf_m = 1'b1;
    if (c) begin
      q.delete();
    end else begin
      if (pv) void'(q.pop_front());
      if (ps) q.push_back(d);
    end
    @(negedge clk);
    wrReq = 1'b0;
    clr = 1'b0;
    outReady = 1'b0;
  endtask

  initial begin
    #1;
    check("rst.count", 32'(count), 0);
    check("rst.empty", 32'(empty), 1);
    check("rst.full", 32'(full), 0);
    check("rst.valid", 32'(outValid), 0);
    check("rst.ovf", 32'(ovf), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fill with 1..4, consumer stalled
    for (int i = 1; i <= 4; i++) step(1, W'(i), 0, 0);
    cmp_model("fill");
    check("fill.count4", 32'(count), 4);
    check("fill.head", 32'(outData), 32'h0001);
    for (int i = 1; i <= 4; i++) begin
      check("drain.order", 32'(outData), 32'(i));
      step(0, '0, 1, 0);
    end
    check("drain.empty", 32'(empty), 1);

    // Full: write with simultaneous pop
    for (int i = 1; i <= 4; i++) step(1, W'(i), 0, 0);
    step(1, 16'h00AA, 1, 0);
    cmp_model("fullpop");
    check("fullpop.count", 32'(count), 4);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("fullpop.aa", 32'(outData), 32'h00AA);
      step(0, '0, 1, 0);
    end

    // Full: dropped write
    for (int i = 1; i <= 4; i++) step(1, W'(16 + i), 0, 0);
    step(1, 16'h00BB, 0, 0);
    cmp_model("drop");
    check("drop.ovf", 32'(ovf), 32'(OVF_EN));
    repeat (4) step(0, '0, 1, 0);
    cmp_model("drop.drained");

    // No bypass into empty buffer
    step(1, 16'h1234, 1, 0);
    check("nobyp.valid", 32'(outValid), 1);
    check("nobyp.data", 32'(outData), 32'h1234);
    step(0, '0, 1, 0);

    // Flush beats a concurrent write
    for (int i = 0; i < 3; i++) step(1, W'(i + 5), 0, 0);
    step(1, 16'h5555, 0, 1);
    check("clr.count", 32'(count), 0);
    check("clr.empty", 32'(empty), 1);
    cmp_model("clr");

    // Mixed rates, pointer wrap
    for (int i = 0; i < 10; i++) begin
      step(i % 3 != 2, W'($urandom), i % 2 == 1, 0);
      cmp_model("wrap");
      check("wrap.le4", 32'(count <= 4), 1);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 6, W'($urandom),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 49) == 0);
      cmp_model("rand");
    end

    // Async reset mid-sequence
    for (int i = 0; i < 3; i++) step(1, W'(i + 9), 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check("arst.count", 32'(count), 0);
    check("arst.empty", 32'(empty), 1);
    check("arst.full", 32'(full), 0);
    check("arst.valid", 32'(outValid), 0);
    check("arst.ovf", 32'(ovf), 0);
    q.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    step(1, 16'h0F0F, 0, 0);
    cmp_model("post");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
